// File: rtl/rom_word_packer_pkg.sv
// Shared types and constants for the HEX-loader byte-to-word packer.
package rom_word_packer_pkg;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    localparam int FIFO_DEPTH_DEFAULT = 8;
    localparam int FIFO_AW_DEFAULT    = 3;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } word_entry_t;

    function automatic logic [1:0] laneBe(input logic lane);
        return lane ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/rom_word_packer_if.sv
// Loader-side byte stream and memory-side word handshake of the packer.
// Optional ROM_PACK_STATS_EN adds the word_count/max_word_addr statistics.
interface rom_word_packer_if;
    logic        in_wr_en;
    logic [14:0] in_wr_addr;
    logic [7:0]  in_wr_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_addr;
    logic [15:0] out_data;
    logic [1:0]  out_be;
    logic        busy;
    logic        overflow;
`ifdef ROM_PACK_STATS_EN
    logic [14:0] word_count;
    logic [13:0] max_word_addr;
`endif

    modport master (
        output in_wr_en, in_wr_addr, in_wr_data, flush, out_ready,
`ifdef ROM_PACK_STATS_EN
        input  word_count, max_word_addr,
`endif
        input  out_valid, out_addr, out_data, out_be, busy, overflow
    );

    modport slave (
        input  in_wr_en, in_wr_addr, in_wr_data, flush, out_ready,
`ifdef ROM_PACK_STATS_EN
        output word_count, max_word_addr,
`endif
        output out_valid, out_addr, out_data, out_be, busy, overflow
    );
endinterface

// File: rtl/rom_word_fifo.sv
// Packed-word FIFO with a registered head; a full FIFO still accepts a push
// when the head is popped in the same cycle.
module rom_word_fifo
    import rom_word_packer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int AW    = FIFO_AW_DEFAULT
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic        i_push,
    input  word_entry_t i_pushEntry,
    input  logic        i_pop,
    output word_entry_t o_head,
    output logic        o_headValid,
    output logic        o_empty,
    output logic        o_overflow
);

    word_entry_t    r_mem [DEPTH];
    word_entry_t    r_head;
    logic           r_headValid;
    logic           r_overflow;
    logic [AW:0]    r_count;
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;

    logic           w_full;
    logic           w_pop;
    logic           w_pushOk;
    logic [AW:0]    w_countNext;
    logic [AW:0]    w_remain;
    logic [AW-1:0]  w_rdPtrNext;

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_pop       = i_pop & r_headValid;
    assign w_pushOk    = i_push & (~w_full | w_pop);
    assign w_remain    = r_count - (AW+1)'(w_pop);
    assign w_countNext = w_remain + (AW+1)'(w_pushOk);
    assign w_rdPtrNext = r_rdPtr + AW'(w_pop);

    always_ff @(posedge clk_74a) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= i_pushEntry;
        end
    end

    // The head register mirrors the oldest entry; when the FIFO is about to
    // hold only the word being pushed, that word bypasses the storage array.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_head      <= '0;
            r_headValid <= 1'b0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
        end else begin
            r_count    <= w_countNext;
            r_rdPtr    <= w_rdPtrNext;
            r_wrPtr    <= r_wrPtr + AW'(w_pushOk);
            r_overflow <= r_overflow | (i_push & ~w_pushOk);
            if (w_countNext == '0) begin
                r_headValid <= 1'b0;
            end else if (w_pop || !r_headValid) begin
                r_headValid <= 1'b1;
                r_head      <= (w_remain == '0) ? i_pushEntry : r_mem[w_rdPtrNext];
            end
        end
    end

    assign o_head      = r_head;
    assign o_headValid = r_headValid;
    assign o_empty     = (r_count == '0);
    assign o_overflow  = r_overflow;

endmodule

// File: rtl/rom_word_packer.sv
// Packs the HEX loader's byte stream into 16-bit little-endian words with byte
// enables. Optional ROM_PACK_STATS_EN adds pop statistics outputs.
module rom_word_packer
    import rom_word_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int FIFO_AW    = FIFO_AW_DEFAULT
) (
    input  logic              clk_74a,
    input  logic              reset_n,
    rom_word_packer_if.slave  bus
);

    logic [13:0]  r_pendAddr;
    logic [7:0]   r_pendLo;
    logic [7:0]   r_pendHi;
    logic [1:0]   r_pendBe;
    logic         r_deferFlush;

    logic         w_lane;
    logic [13:0]  w_waddr;
    logic [1:0]   w_laneBe;
    logic         w_flushNow;
    logic         w_merge;
    logic         w_push;
    word_entry_t  w_pushEntry;
    logic [13:0]  w_nextAddr;
    logic [7:0]   w_nextLo;
    logic [7:0]   w_nextHi;
    logic [1:0]   w_nextBe;
    logic         w_nextDefer;
    word_entry_t  w_head;
    logic         w_headValid;
    logic         w_fifoEmpty;
    logic         w_overflow;
    logic         w_pop;

    // A byte either merges into the open word or closes it and opens a new one;
    // a flush that arrives with a byte is replayed on the following idle cycle.
    always_comb begin
        w_lane      = bus.in_wr_addr[0];
        w_waddr     = bus.in_wr_addr[14:1];
        w_laneBe    = laneBe(w_lane);
        w_flushNow  = ~bus.in_wr_en & (bus.flush | r_deferFlush);
        w_merge     = (r_pendBe != BE_NONE) && (w_waddr == r_pendAddr) &&
                      ((r_pendBe & w_laneBe) == BE_NONE);
        w_push      = 1'b0;
        w_pushEntry.addr = r_pendAddr;
        w_pushEntry.data = {r_pendHi, r_pendLo};
        w_pushEntry.be   = r_pendBe;
        w_nextAddr  = r_pendAddr;
        w_nextLo    = r_pendLo;
        w_nextHi    = r_pendHi;
        w_nextBe    = r_pendBe;
        w_nextDefer = r_deferFlush;

        if (bus.in_wr_en) begin
            if (w_merge) begin
                if (w_lane) w_nextHi = bus.in_wr_data;
                else        w_nextLo = bus.in_wr_data;
                w_nextBe = r_pendBe | w_laneBe;
                if (w_nextBe == BE_WORD) begin
                    w_push           = 1'b1;
                    w_pushEntry.data = {w_nextHi, w_nextLo};
                    w_pushEntry.be   = BE_WORD;
                    w_nextBe         = BE_NONE;
                end
            end else begin
                w_push     = (r_pendBe != BE_NONE);
                w_nextAddr = w_waddr;
                w_nextLo   = w_lane ? 8'h00 : bus.in_wr_data;
                w_nextHi   = w_lane ? bus.in_wr_data : 8'h00;
                w_nextBe   = w_laneBe;
            end
            if (bus.flush) w_nextDefer = 1'b1;
        end else if (w_flushNow) begin
            w_nextDefer = 1'b0;
            if (r_pendBe != BE_NONE) begin
                w_push   = 1'b1;
                w_nextBe = BE_NONE;
            end
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_pendAddr   <= '0;
            r_pendLo     <= '0;
            r_pendHi     <= '0;
            r_pendBe     <= BE_NONE;
            r_deferFlush <= 1'b0;
        end else begin
            r_pendAddr   <= w_nextAddr;
            r_pendLo     <= w_nextLo;
            r_pendHi     <= w_nextHi;
            r_pendBe     <= w_nextBe;
            r_deferFlush <= w_nextDefer;
        end
    end

    assign w_pop = w_headValid & bus.out_ready;

    rom_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_74a     (clk_74a),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_headValid (w_headValid),
        .o_empty     (w_fifoEmpty),
        .o_overflow  (w_overflow)
    );

    assign bus.out_valid = w_headValid;
    assign bus.out_addr  = w_head.addr;
    assign bus.out_data  = w_head.data;
    assign bus.out_be    = w_head.be;
    assign bus.overflow  = w_overflow;
    assign bus.busy      = (r_pendBe != BE_NONE) | ~w_fifoEmpty | r_deferFlush;

`ifdef ROM_PACK_STATS_EN
    logic [14:0] r_wordCount;
    logic [13:0] r_maxWordAddr;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_wordCount   <= '0;
            r_maxWordAddr <= '0;
        end else if (w_pop) begin
            if (r_wordCount != '1) r_wordCount <= r_wordCount + 15'd1;
            if (w_head.addr > r_maxWordAddr) r_maxWordAddr <= w_head.addr;
        end
    end

    assign bus.word_count    = r_wordCount;
    assign bus.max_word_addr = r_maxWordAddr;
`endif

endmodule
